// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and sizing helpers for the nibble-serial adder.
// The serial datapath processes one 4-bit nibble per clock.
package nibble_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int nibble_count(input int width);
        return width / 4;
    endfunction

    // The nibble counter is never narrower than one bit, even for a single nibble.
    function automatic int cnt_width(input int width);
        int n;
        n = width / 4;
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_cla4.sv
// Exact 4-bit carry-lookahead slice: s = a + b + c0 (low 4 bits), c4 = carry out.
module MCLA_4_c_c4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c0,
    output logic [3:0] s,
    output logic       c4
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat two-level generate/propagate term, no ripple.
    assign c[0] = c0;
    assign c[1] = g[0] | (p[0] & c0);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c0);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c0);

    assign s  = p ^ c[3:0];
    assign c4 = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Adds two WIDTH-bit operands plus carry-in over WIDTH/4 cycles through one 4-bit CLA slice.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [1:0]       state_o
);

    localparam int N  = nibble_count(WIDTH);
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [3:0] slice_s;
    logic       slice_c4;

    MCLA_4_c_c4 u_slice (
        .a  (a_sh_q[3:0]),
        .b  (b_sh_q[3:0]),
        .c0 (carry_q),
        .s  (slice_s),
        .c4 (slice_c4)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // New nibble enters at the top so after N shifts nibble 0 sits at the bottom.
                sum_d              = sum_q >> 4;
                sum_d[WIDTH-1 -: 4] = slice_s;
                a_sh_d             = a_sh_q >> 4;
                b_sh_d             = b_sh_q >> 4;
                carry_d            = slice_c4;
                cnt_d              = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign sum       = sum_q;
    assign cout      = carry_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder at WIDTH 16, 4 and 32 against a+b+cin arithmetic.
module tb_nibble_serial_adder;
    import nibble_serial_adder_pkg::*;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic         in_valid = 1'b0, cin = 1'b0, out_ready = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         in_ready, out_valid, cout;
    logic [W-1:0] sum;
    logic [1:0]   state_dbg;

    logic       n_in_valid = 1'b0, n_cin = 1'b0, n_out_ready = 1'b0;
    logic [3:0] n_a = '0, n_b = '0;
    logic       n_in_ready, n_out_valid, n_cout;
    logic [3:0] n_sum;
    logic [1:0] n_state_dbg;

    logic        w_in_valid = 1'b0, w_cin = 1'b0, w_out_ready = 1'b0;
    logic [31:0] w_a = '0, w_b = '0;
    logic        w_in_ready, w_out_valid, w_cout;
    logic [31:0] w_sum;
    logic [1:0]  w_state_dbg;

    int vectors = 0;
    int errors  = 0;
    logic [W:0] exp_q[$];

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .state_o(state_dbg)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .a(n_a), .b(n_b), .cin(n_cin), .out_valid(n_out_valid), .out_ready(n_out_ready),
        .sum(n_sum), .cout(n_cout), .state_o(n_state_dbg)
    );

    nibble_serial_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .a(w_a), .b(w_b), .cin(w_cin), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .sum(w_sum), .cout(w_cout), .state_o(w_state_dbg)
    );

    function automatic logic [W:0] ref16(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + (W+1)'(c);
    endfunction

    // Caller is #1 after an edge with the DUT idle; returns once out_valid is seen or the budget runs out.
    task automatic drive16(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                           output int lat, output bit timed_out);
        in_valid = 1'b1;
        a = x;
        b = y;
        cin = c;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        timed_out = !out_valid;
    endtask

    task automatic release16();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        vectors++;
        if (sum !== '0 || cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_data sum=%h cout=%b want 0000/0", sum, cout);
        end
        vectors++;
        if (state_dbg !== 2'(IDLE) || n_state_dbg !== 2'(IDLE) || w_state_dbg !== 2'(IDLE)) begin
            errors++;
            $display("FAIL reset_state %0d/%0d/%0d want IDLE", state_dbg, n_state_dbg, w_state_dbg);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [W-1:0] ta[5] = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h0101};
        logic [W-1:0] tb_[5] = '{16'h4321, 16'h0001, 16'h0000, 16'h8000, 16'h0202};
        logic         tc[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [W:0]   te[5] = '{17'h05555, 17'h10000, 17'h10000, 17'h10000, 17'h00303};
        int lat;
        bit to;
        for (int i = 0; i < 5; i++) begin
            drive16(ta[i], tb_[i], tc[i], lat, to);
            vectors++;
            if (to || {cout, sum} !== te[i]) begin
                errors++;
                $display("FAIL directed_%0d got %b_%h want %h (timeout=%0d)", i, cout, sum, te[i], to);
            end
            vectors++;
            if (lat !== 4) begin
                errors++;
                $display("FAIL latency_%0d got %0d want 4", i, lat);
            end
            release16();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit to;
        drive16(16'h00F0, 16'h0010, 1'b0, lat, to);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            a = W'($urandom);
            b = W'($urandom);
            vectors++;
            if (to || out_valid !== 1'b1 || sum !== 16'h0100 || cout !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_%0d ov=%b sum=%h cout=%b ir=%b want 1/0100/0/0",
                         k, out_valid, sum, cout, in_ready);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        release16();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ignored in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        bit to;
        bit saw_valid;
        in_valid = 1'b1;
        a = 16'h1234;
        b = 16'h1111;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrun_reset ov=%b sum=%h cout=%b ir=%b want 0/0000/0/1",
                     out_valid, sum, cout, in_ready);
        end
        @(negedge clk) rst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) saw_valid = 1'b1;
        end
        vectors++;
        if (saw_valid) begin
            errors++;
            $display("FAIL aborted_output got out_valid=1 want 0");
        end
        drive16(16'h0101, 16'h0202, 1'b0, lat, to);
        vectors++;
        if (to || {cout, sum} !== 17'h00303) begin
            errors++;
            $display("FAIL after_reset got %b_%h want 0_0303", cout, sum);
        end
        release16();
    endtask

    task automatic test_random16(input int n_ops);
        int lat;
        bit to;
        logic [W:0] exp;
        for (int i = 0; i < n_ops; i++) begin
            logic [W-1:0] x, y;
            logic c;
            x = W'($urandom);
            y = W'($urandom);
            c = 1'($urandom);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            exp_q.push_back(ref16(x, y, c));
            drive16(x, y, c, lat, to);
            exp = exp_q.pop_front();
            vectors++;
            if (to || {cout, sum} !== exp || lat !== 4) begin
                errors++;
                $display("FAIL random16_%0d got %b_%h lat %0d want %h lat 4", i, cout, sum, lat, exp);
            end
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            vectors++;
            if (out_valid !== 1'b1 || {cout, sum} !== exp) begin
                errors++;
                $display("FAIL hold16_%0d got ov=%b %b_%h want 1 %h", i, out_valid, cout, sum, exp);
            end
            release16();
        end
    endtask

    task automatic test_width4(input int n_ops);
        for (int i = 0; i < n_ops; i++) begin
            logic [3:0] x, y;
            logic c;
            logic [4:0] exp;
            int lat;
            x = 4'($urandom);
            y = 4'($urandom);
            c = 1'($urandom);
            exp = {1'b0, x} + {1'b0, y} + 5'(c);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            n_in_valid = 1'b1; n_a = x; n_b = y; n_cin = c;
            @(posedge clk); #1;
            n_in_valid = 1'b0; n_a = 4'($urandom); n_b = 4'($urandom); n_cin = 1'($urandom);
            lat = 0;
            while (!n_out_valid && lat < 10) begin @(posedge clk); #1; lat++; end
            vectors++;
            if (!n_out_valid || {n_cout, n_sum} !== exp || lat !== 1) begin
                errors++;
                $display("FAIL width4_%0d got %b_%h lat %0d want %h lat 1", i, n_cout, n_sum, lat, exp);
            end
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            n_out_ready = 1'b1;
            @(posedge clk); #1;
            n_out_ready = 1'b0;
        end
    endtask

    task automatic test_width32(input int n_ops);
        for (int i = 0; i < n_ops; i++) begin
            logic [31:0] x, y;
            logic c;
            logic [32:0] exp;
            int lat;
            x = $urandom;
            y = $urandom;
            c = 1'($urandom);
            if (i == 0) begin x = 32'hFFFF_FFFF; y = 32'h0; c = 1'b1; end
            exp = {1'b0, x} + {1'b0, y} + 33'(c);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            w_in_valid = 1'b1; w_a = x; w_b = y; w_cin = c;
            @(posedge clk); #1;
            w_in_valid = 1'b0; w_a = $urandom; w_b = $urandom; w_cin = 1'($urandom);
            lat = 0;
            while (!w_out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
            vectors++;
            if (!w_out_valid || {w_cout, w_sum} !== exp || lat !== 8) begin
                errors++;
                $display("FAIL width32_%0d got %b_%h lat %0d want %h lat 8", i, w_cout, w_sum, lat, exp);
            end
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            w_out_ready = 1'b1;
            @(posedge clk); #1;
            w_out_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_random16(3000);
        test_width4(800);
        test_width32(600);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
